// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : 8N1 UART receiver. Deserialises frames from rx, presents each
//             good byte on dato with a one-cycle init strobe, and flags stop
//             bits sampled low with a one-cycle frame_err strobe.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dato,
  output logic       init,
  output logic       frame_err,
  output logic       busy
);

  localparam int          HALF_BIT    = CLKS_PER_BIT / 2;
  localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_dato;
  logic        r_init;
  logic        r_frame_err;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_dato_nxt;
  logic        w_init_nxt;
  logic        w_frame_err_nxt;
  logic        w_rx_s;

  assign w_rx_s = r_sync2;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State, counters, data path and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_dato      <= 8'd0;
      r_init      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_dato      <= w_dato_nxt;
      r_init      <= w_init_nxt;
      r_frame_err <= w_frame_err_nxt;
      // Registered from the next state so busy tracks (state != IDLE) exactly.
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic: start-bit qualification at mid-bit, then one sample
  // per bit period so every data/stop sample lands near bit centre.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_dato_nxt      = r_dato;
    w_init_nxt      = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 16'd0;
        end
      end

      S_START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = 16'd0;
          if (!w_rx_s) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            // Line went high again before mid-bit: a glitch, not a frame.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt              = 16'd0;
          w_shift_nxt[r_bit_idx] = w_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_STOP: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt = 16'd0;
          if (w_rx_s) begin
            w_dato_nxt  = r_shift;
            w_init_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_BREAK: begin
        // Wait out a held-low line so it cannot re-trigger frame after frame.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign dato      = r_dato;
  assign init      = r_init;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire
